// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_e;

    localparam logic [3:0] COL0     = 4'b1110;
    localparam logic [3:0] COL1     = 4'b1101;
    localparam logic [3:0] COL2     = 4'b1011;
    localparam logic [3:0] COL3     = 4'b0111;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Lowest-numbered active-low row wins when several rows read low.
    function automatic logic [1:0] first_low(input logic [3:0] r);
        if (!r[0]) return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    return COL0;
            2'd1:    return COL1;
            2'd2:    return COL2;
            default: return COL3;
        endcase
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Resettable, enable-gated prescaler: one-cycle tick at the terminal count of 0..SCAN_TICKS-1.
module scan_tick_gen #(
    parameter int SCAN_TICKS = 16384
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [CW-1:0] TERM = CW'(SCAN_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable)
            cnt_d = '0;
        else if (cnt_q == TERM)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Gating with enable lets a same-cycle disable suppress the tick.
    assign tick = enable && (cnt_q == TERM);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column, debounces press and release, one code per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = 16384,
    parameter int DEBOUNCE   = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_down
);

    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE);

    logic [3:0] row_meta_q, row_s_q;
    logic       tick;
    state_e     state_q, state_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic       idle_q, idle_d;
    logic [1:0] row_idx_q, row_idx_d;
    logic [3:0] db_cnt_q, db_cnt_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       down_q, down_d;
    logic       cand;
    logic [3:0] db_inc;

    scan_tick_gen #(.SCAN_TICKS(SCAN_TICKS)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_s_q    <= row_meta_q;
        end
    end

    // Only the latched candidate row is watched once a press is in progress.
    assign cand   = row_s_q[row_idx_q];
    assign db_inc = db_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        idle_d    = idle_q;
        row_idx_d = row_idx_q;
        db_cnt_d  = db_cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        down_d    = down_q;
        if (!enable) begin
            state_d   = ST_SCAN;
            col_idx_d = 2'd0;
            idle_d    = 1'b1;
            db_cnt_d  = 4'd0;
            down_d    = 1'b0;
        end else begin
            idle_d = 1'b0;
            if (tick) begin
                case (state_q)
                    ST_SCAN: begin
                        if (row_s_q == 4'hF) begin
                            col_idx_d = col_idx_q + 2'd1;
                        end else begin
                            row_idx_d = first_low(row_s_q);
                            db_cnt_d  = 4'd1;
                            state_d   = ST_DEBOUNCE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!cand) begin
                            db_cnt_d = db_inc;
                            if (db_inc == DB_MAX) begin
                                code_d  = {row_idx_q, col_idx_q};
                                valid_d = 1'b1;
                                down_d  = 1'b1;
                                state_d = ST_PRESSED;
                            end
                        end else begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end
                    ST_PRESSED: begin
                        if (cand) begin
                            db_cnt_d = 4'd1;
                            state_d  = ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (cand) begin
                            db_cnt_d = db_inc;
                            if (db_inc == DB_MAX) begin
                                down_d    = 1'b0;
                                state_d   = ST_SCAN;
                                col_idx_d = col_idx_q + 2'd1;
                            end
                        end else begin
                            state_d = ST_PRESSED;
                        end
                    end
                    default: state_d = ST_SCAN;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SCAN;
            col_idx_q <= 2'd0;
            idle_q    <= 1'b0;
            row_idx_q <= 2'd0;
            db_cnt_q  <= 4'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            idle_q    <= idle_d;
            row_idx_q <= row_idx_d;
            db_cnt_q  <= db_cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            down_q    <= down_d;
        end
    end

    assign col       = idle_q ? COL_IDLE : col_drive(col_idx_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule
